// File: rtl/fma_norm_shifter.sv
// fma_norm_shifter
// Multi-cycle post-normalization shifter for the FMA leading-zero
// anticipation path. It takes a positive sum magnitude together with the
// anticipated left-shift count and shifts the sum left a few count bits per
// cycle. It then applies the one-bit LZA correction when the anticipated
// count is one short, and flags anticipation errors.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush             synchronous flush, drops any in-flight operation
//   in_valid/in_ready input handshake for Sum/SCnt
//   Sum, SCnt         magnitude to normalize, anticipated shift (0..WIDTH)
//   out_valid/out_ready output handshake
//   Norm, NormCnt     normalized magnitude, total shift applied
//   Corr, Zero, LzaErr  correction applied, zero input, anticipation error
module fma_norm_shifter #(
  parameter int WIDTH = 162,
  parameter int SPC   = 2,
  localparam int SW   = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  Sum,
  input  logic [SW-1:0]     SCnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  Norm,
  output logic [SW:0]       NormCnt,
  output logic              Corr,
  output logic              Zero,
  output logic              LzaErr
);

  localparam int K  = (SW + SPC - 1) / SPC;
  localparam int GW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CORRECT, DONE} state_t;

  state_t state, nextState;

  logic [WIDTH-1:0] sumReg;
  logic [SW-1:0]    scntReg;
  logic             zeroReg;
  logic             sticky;
  logic [GW-1:0]    grp;

  logic [SW-1:0]      amt;
  logic [2*WIDTH-1:0] ext;
  logic [WIDTH-1:0]   shifted;
  logic               lost;

  logic [WIDTH-1:0] corrNorm;
  logic [SW:0]      corrCnt;
  logic             corrFlag;
  logic             corrErr;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) nextState = SHIFT;
        SHIFT:   if (int'(grp) == K - 1) nextState = CORRECT;
        CORRECT: nextState = DONE;
        DONE:    if (out_ready) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Handshake outputs depend only on the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Shift amount for the current group. The group's count bits keep their
  // positional weight, so summing all groups gives exactly SCnt. The upper
  // half of the double-width shift holds the bits pushed past the MSB.
  always_comb begin
    amt = '0;
    for (int b = 0; b < SW; b++) begin
      if ((b / SPC) == int'(grp)) amt[b] = scntReg[b];
    end
    ext = {{WIDTH{1'b0}}, sumReg} << amt;
    if (int'(amt) >= WIDTH) begin
      shifted = '0;
      lost    = |sumReg;
    end else begin
      shifted = ext[WIDTH-1:0];
      lost    = |ext[2*WIDTH-1:WIDTH];
    end
  end

  // Final correction. Sticky-out means the anticipated count overshot.
  // A clear MSB means the count was short, so one extra bit of shift is
  // applied, and anything still unnormalized after that is an error.
  always_comb begin
    corrNorm = sumReg;
    corrCnt  = {1'b0, scntReg};
    corrFlag = 1'b0;
    corrErr  = 1'b0;
    if (zeroReg) begin
      corrNorm = '0;
    end else if (sticky) begin
      corrErr = 1'b1;
    end else if (!sumReg[WIDTH-1]) begin
      corrNorm = {sumReg[WIDTH-2:0], 1'b0};
      corrCnt  = {1'b0, scntReg} + {{SW{1'b0}}, 1'b1};
      corrFlag = 1'b1;
      corrErr  = ~sumReg[WIDTH-2];
    end
  end

  // Datapath and result registers. The results load only when leaving
  // CORRECT, so they stay stable throughout DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sumReg  <= '0;
      scntReg <= '0;
      zeroReg <= 1'b0;
      sticky  <= 1'b0;
      grp     <= '0;
      Norm    <= '0;
      NormCnt <= '0;
      Corr    <= 1'b0;
      Zero    <= 1'b0;
      LzaErr  <= 1'b0;
    end else if (flush) begin
      sticky  <= 1'b0;
      grp     <= '0;
      Norm    <= '0;
      NormCnt <= '0;
      Corr    <= 1'b0;
      Zero    <= 1'b0;
      LzaErr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sumReg  <= Sum;
            scntReg <= SCnt;
            zeroReg <= (Sum == '0);
            sticky  <= 1'b0;
            grp     <= '0;
          end
        end
        SHIFT: begin
          sumReg <= shifted;
          sticky <= sticky | lost;
          grp    <= grp + GW'(1);
        end
        CORRECT: begin
          Norm    <= corrNorm;
          NormCnt <= corrCnt;
          Corr    <= corrFlag;
          Zero    <= zeroReg;
          LzaErr  <= corrErr;
        end
        default: ;
      endcase
    end
  end

endmodule
